// File: rtl/msg_dispatch_pkg.sv
// Shared constants, state encoding and helpers for msg_dispatcher.
package msg_dispatch_pkg;

    // Dispatcher FSM encoding (kept as plain constants for legacy tools)
    typedef logic [0:0] state_t;
    localparam state_t StIdle    = 1'b0;
    localparam state_t StDeliver = 1'b1;

    // Destination ID field inside the bridge header
    localparam int unsigned DEST_ID_WIDTH = 8;
    localparam int unsigned DEST_ID_LSB   = 0;

    localparam logic [DEST_ID_WIDTH-1:0] BROADCAST_ID = 8'hFF;

    localparam int unsigned DROP_COUNT_WIDTH = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(
        input logic [DROP_COUNT_WIDTH-1:0] val
    );
        return (&val) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/msg_dispatch_timer.sv
// Delivery watchdog: counts DELIVER cycles, flags the last permitted one.
module msg_dispatch_timer
    import msg_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic expired_out
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear has priority over counting
    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (enable_in) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_out = (count_q == LastCnt);

endmodule

// File: rtl/msg_dispatcher.sv
// Latches bridge frames and hands them to per-destination valid/ready ports.
// Optional build macro MSG_DISPATCH_BROADCAST_EN: header ID 8'hFF targets all ports.
module msg_dispatcher
    import msg_dispatch_pkg::*;
#(
    parameter int unsigned MESSAGE_SIZE   = 512,
    parameter int unsigned HEADER_SIZE    = 32,
    parameter int unsigned NUM_DEST       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [MESSAGE_SIZE-1:0]     bdge_message_in,
    input  logic [HEADER_SIZE-1:0]      bdge_header_in,
    input  logic                        bdge_valid_in,
    output logic                        ctrl_ready_out,
    output logic [MESSAGE_SIZE-1:0]     dest_message_out,
    output logic [HEADER_SIZE-1:0]      dest_header_out,
    output logic [NUM_DEST-1:0]         dest_valid_out,
    input  logic [NUM_DEST-1:0]         dest_ready_in,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count_out,
    output logic                        busy_out
);

    state_t                      state_q, state_d;
    logic [NUM_DEST-1:0]         mask_q, mask_d;
    logic [HEADER_SIZE-1:0]      hdr_q, hdr_d;
    logic [MESSAGE_SIZE-1:0]     msg_q, msg_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;

    logic [DEST_ID_WIDTH-1:0] dest_id;
    logic [NUM_DEST-1:0]      accept_mask;
    logic [NUM_DEST-1:0]      remaining;
    logic                     timer_clr;
    logic                     timer_en;
    logic                     timer_expired;

    assign dest_id = bdge_header_in[DEST_ID_LSB +: DEST_ID_WIDTH];

    msg_dispatch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_in    (timer_clr),
        .enable_in   (timer_en),
        .expired_out (timer_expired)
    );

    // Decode the incoming header's destination into a target mask
    always_comb begin
        accept_mask = '0;
        if (32'(dest_id) < NUM_DEST) begin
            accept_mask = NUM_DEST'(1) << dest_id;
        end
`ifdef MSG_DISPATCH_BROADCAST_EN
        else if (dest_id == BROADCAST_ID) begin
            accept_mask = '1;
        end
`endif
    end

    // Accept/deliver/timeout sequencing
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        hdr_d     = hdr_q;
        msg_d     = msg_q;
        drop_d    = drop_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        remaining = mask_q & ~dest_ready_in;

        case (state_q)
            StIdle: begin
                if (bdge_valid_in) begin
                    hdr_d     = bdge_header_in;
                    msg_d     = bdge_message_in;
                    timer_clr = 1'b1;
                    if (accept_mask != '0) begin
                        mask_d  = accept_mask;
                        state_d = StDeliver;
                    end else begin
                        drop_d = sat_inc(drop_q);
                    end
                end
            end
            StDeliver: begin
                timer_en = 1'b1;
                if (remaining == '0) begin
                    // Completion beats a coincident timeout
                    mask_d  = '0;
                    state_d = StIdle;
                end else if (timer_expired) begin
                    mask_d  = '0;
                    drop_d  = sat_inc(drop_q);
                    state_d = StIdle;
                end else begin
                    mask_d = remaining;
                end
            end
            default: begin
                mask_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            mask_q  <= '0;
            hdr_q   <= '0;
            msg_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            hdr_q   <= hdr_d;
            msg_q   <= msg_d;
            drop_q  <= drop_d;
        end
    end

    // Mask is always zero outside DELIVER, so it drives valid directly
    assign ctrl_ready_out   = (state_q == StIdle);
    assign busy_out         = (state_q == StDeliver);
    assign dest_valid_out   = mask_q;
    assign dest_header_out  = hdr_q;
    assign dest_message_out = msg_q;
    assign drop_count_out   = drop_q;

endmodule

// File: tb/tb_msg_dispatcher.sv
// Directed bench for msg_dispatcher with a frame-level reference model.
module tb_msg_dispatcher;

    localparam int MSG_W = 512;
    localparam int HDR_W = 32;
    localparam int ND    = 4;
    localparam int TO    = 16;
`ifdef MSG_DISPATCH_BROADCAST_EN
    localparam int BC = 1;
`else
    localparam int BC = 0;
`endif
    // Drop count after the broadcast step: unchanged when broadcast is built in
    localparam int DropAfterBc = (BC != 0) ? 1 : 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [MSG_W-1:0] msg_in = '0;
    logic [HDR_W-1:0] hdr_in = '0;
    logic             vin = 1'b0;
    logic             crdy;
    logic [MSG_W-1:0] dmsg;
    logic [HDR_W-1:0] dhdr;
    logic [ND-1:0]    dval;
    logic [ND-1:0]    drdy = '0;
    logic [15:0]      drop;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    msg_dispatcher #(
        .MESSAGE_SIZE   (MSG_W),
        .HEADER_SIZE    (HDR_W),
        .NUM_DEST       (ND),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .bdge_message_in  (msg_in),
        .bdge_header_in   (hdr_in),
        .bdge_valid_in    (vin),
        .ctrl_ready_out   (crdy),
        .dest_message_out (dmsg),
        .dest_header_out  (dhdr),
        .dest_valid_out   (dval),
        .dest_ready_in    (drdy),
        .drop_count_out   (drop),
        .busy_out         (busy)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: one frame in flight, its outstanding targets and its age
    logic             m_busy  = 1'b0;
    logic [ND-1:0]    m_pend  = '0;
    logic [HDR_W-1:0] m_hdr   = '0;
    logic [MSG_W-1:0] m_msg   = '0;
    int               m_drops = 0;
    int               m_age   = 0;
    logic [HDR_W-1:0] dlog[$];

    always @(negedge clk) begin
        logic [ND-1:0] tgt;
        logic [ND-1:0] left;
        int            id;
        chk("ctrl_ready", crdy, !m_busy);
        chk("busy", busy, m_busy);
        chk("dest_valid", dval, m_busy ? m_pend : '0);
        chk("drop_count", drop, m_drops);
        chk("dest_header", dhdr, m_hdr);
        chk("dest_message", dmsg, m_msg);
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                if (dval[d] && drdy[d]) dlog.push_back(dhdr);
            end
        end
        if (rst) begin
            m_busy = 1'b0; m_pend = '0; m_hdr = '0; m_msg = '0; m_drops = 0; m_age = 0;
        end else if (!m_busy) begin
            if (vin) begin
                m_hdr = hdr_in;
                m_msg = msg_in;
                id = int'(hdr_in[7:0]);
                tgt = '0;
                if (id < ND) tgt[id] = 1'b1;
                else if (BC != 0 && id == 255) tgt = '1;
                if (tgt != '0) begin
                    m_busy = 1'b1; m_pend = tgt; m_age = 0;
                end else begin
                    m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
                end
            end
        end else begin
            left = m_pend & ~drdy;
            m_age++;
            if (left == '0) begin
                m_busy = 1'b0; m_pend = '0;
            end else if (m_age == TO) begin
                m_busy = 1'b0; m_pend = '0;
                m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
            end else begin
                m_pend = left;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [MSG_W-1:0] m1;
        logic [MSG_W-1:0] ma;
        logic [MSG_W-1:0] mb;
        int               n0;
        m1 = {8{64'h0123_4567_89ab_cdef}};
        ma = {16{32'hA5A5_0000}};
        mb = {16{32'h5A5A_1111}};

        repeat (2) tick();
        rst = 1'b0;
        chk("lit_reset_ready", crdy, 1'b1);
        chk("lit_reset_valid", dval, 4'b0000);
        chk("lit_reset_drop", drop, 16'd0);
        chk("lit_reset_busy", busy, 1'b0);

        // 1: unicast to port 2, ready already high
        hdr_in = 32'h0000_0002; msg_in = m1; vin = 1'b1; drdy = 4'b0100;
        tick();
        vin = 1'b0;
        chk("lit_uni_valid", dval, 4'b0100);
        chk("lit_uni_ready_low", crdy, 1'b0);
        chk("lit_uni_header", dhdr, 32'h0000_0002);
        chk("lit_uni_message", dmsg, m1);
        tick();
        drdy = '0;
        chk("lit_uni_done_valid", dval, 4'b0000);
        chk("lit_uni_done_ready", crdy, 1'b1);
        chk("lit_uni_drop", drop, 16'd0);

        // 2: unknown ID is dropped without stalling the bridge
        hdr_in = 32'hFAFA_FA07; vin = 1'b1;
        tick();
        vin = 1'b0;
        chk("lit_unk_valid", dval, 4'b0000);
        chk("lit_unk_drop", drop, 16'd1);
        chk("lit_unk_ready", crdy, 1'b1);

        // 3: broadcast, ready bits arrive staggered
        hdr_in = 32'hBCBC_BCFF; vin = 1'b1;
        tick();
        vin = 1'b0;
`ifdef MSG_DISPATCH_BROADCAST_EN
        chk("lit_bc_d1", dval, 4'b1111);
        drdy = 4'b0100;
        tick();
        chk("lit_bc_d2", dval, 4'b1011);
        drdy = 4'b0110;
        tick();
        chk("lit_bc_d3", dval, 4'b1001);
        drdy = 4'b1110;
        tick();
        chk("lit_bc_d4", dval, 4'b0001);
        drdy = 4'b1111;
        tick();
`endif
        drdy = '0;
        chk("lit_bc_end_valid", dval, 4'b0000);
        chk("lit_bc_end_ready", crdy, 1'b1);
        chk("lit_bc_drop", drop, 16'(DropAfterBc));

        // 4a: timeout with a silent consumer
        hdr_in = 32'h0000_0001; vin = 1'b1;
        tick();
        vin = 1'b0;
        for (int i = 0; i < TO; i++) begin
            chk("lit_to_valid_held", dval, 4'b0010);
            tick();
        end
        chk("lit_to_valid_off", dval, 4'b0000);
        chk("lit_to_drop", drop, 16'(DropAfterBc + 1));

        // 4b: ready on the last permitted cycle still delivers
        vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (TO - 1) tick();
        chk("lit_to_last_valid", dval, 4'b0010);
        drdy = 4'b0010;
        tick();
        drdy = '0;
        chk("lit_to_last_done", dval, 4'b0000);
        chk("lit_to_last_drop", drop, 16'(DropAfterBc + 1));

        // 5: reset in the middle of a delivery
        hdr_in = 32'h0000_0003; vin = 1'b1;
        tick();
        vin = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("lit_rst_valid", dval, 4'b0000);
        chk("lit_rst_ready", crdy, 1'b1);
        chk("lit_rst_drop", drop, 16'd0);

        // 6: second frame held off by backpressure, then accepted
        n0 = dlog.size();
        hdr_in = 32'h0000_0000; msg_in = ma; vin = 1'b1;
        tick();
        hdr_in = 32'h0000_0001; msg_in = mb;
        chk("lit_bp_ready_low", crdy, 1'b0);
        chk("lit_bp_hold_hdr", dhdr, 32'h0000_0000);
        tick();
        chk("lit_bp_hold_msg", dmsg, ma);
        drdy = 4'b0001;
        tick();
        drdy = '0;
        chk("lit_bp_idle_ready", crdy, 1'b1);
        tick();
        vin = 1'b0;
        chk("lit_bp_b_valid", dval, 4'b0010);
        chk("lit_bp_b_hdr", dhdr, 32'h0000_0001);
        chk("lit_bp_b_msg", dmsg, mb);
        drdy = 4'b0010;
        tick();
        drdy = '0;
        chk("lit_bp_end_valid", dval, 4'b0000);
        chk("lit_bp_drop", drop, 16'd0);
        chk("lit_bp_count", dlog.size() - n0, 2);
        if (dlog.size() >= n0 + 2) begin
            chk("lit_bp_order_a", dlog[n0], 32'h0000_0000);
            chk("lit_bp_order_b", dlog[n0 + 1], 32'h0000_0001);
        end
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_dispatcher.md
Name: msg_dispatcher

Overview:
Downstream controller for uart_rx_bridge. Owns the bridge's ctrl_ready_in handshake and latches each completed header+message. Decodes a destination ID from the header and delivers the frame over per-destination valid/ready ports (unicast, or broadcast when enabled). Frames with unknown IDs or stalled consumers are dropped and counted, so the UART receive path never wedges.

Parameters:
MESSAGE_SIZE, 512, message width in bits (matches bridge)
HEADER_SIZE, 32, header width in bits (matches bridge)
NUM_DEST, 4, number of consumer ports (1..8)
TIMEOUT_CYCLES, 1000000, maximum DELIVER cycles before abort (>=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
bdge_message_in  input  MESSAGE_SIZE  message from bridge message_out
bdge_header_in  input  HEADER_SIZE  header from bridge header_out
bdge_valid_in  input  1  bridge bdge_valid_out
ctrl_ready_out  output  1  drives bridge ctrl_ready_in
dest_message_out  output  MESSAGE_SIZE  latched message, shared by all destinations
dest_header_out  output  HEADER_SIZE  latched header, shared by all destinations
dest_valid_out  output  NUM_DEST  per-destination valid
dest_ready_in  input  NUM_DEST  per-destination ready
drop_count_out  output  16  saturating count of dropped frames
busy_out  output  1  high while in DELIVER

Behaviour:
- Reset values: ctrl_ready_out=1, dest_valid_out=0, dest_header_out=0, dest_message_out=0, drop_count_out=0, busy_out=0, state=IDLE, pending mask=0, timer=0.
- Destination ID = bdge_header_in[7:0].
- IDLE state:
  - ctrl_ready_out=1.
  - Accept occurs when bdge_valid_in && ctrl_ready_out. On that edge: latch header and message, clear timer, compute pending mask.
  - ID < NUM_DEST: mask = one-hot(ID).
  - ID = 8'hFF with broadcast enabled: mask = all ones.
  - Any other ID: mask = 0.
  - Mask nonzero: go to DELIVER. dest_valid_out = mask from the next cycle; ctrl_ready_out=0 and busy_out=1 from the next cycle.
  - Mask zero: increment drop_count_out (saturate at 16'hFFFF) and stay in IDLE. ctrl_ready_out stays 1, so back-to-back accepts are allowed.
- DELIVER state:
  - dest_valid_out = pending mask. Header and message outputs are held stable.
  - Each cycle, clear every bit d with dest_valid_out[d] && dest_ready_in[d]. Multiple bits may clear in the same cycle.
  - When the mask becomes 0: return to IDLE. ctrl_ready_out=1 on the following cycle.
  - Timer increments each DELIVER cycle.
  - If timer == TIMEOUT_CYCLES-1 and the mask does not become 0 this cycle: clear the mask, increment drop_count_out once, go to IDLE. Total valid time is exactly TIMEOUT_CYCLES cycles.
  - Completion and timeout in the same cycle: completion wins, no drop counted.
- Valid rules: valid is never deasserted before ready or timeout. Valid never reasserts for a destination that has already accepted the current frame.
- Bridge backpressure: while in DELIVER, the bridge holds its frame (ctrl_ready_out=0). The held frame is accepted in the first IDLE cycle.
- Reset mid-DELIVER: all outputs return to reset values on the next edge. The frame is discarded and not counted.

Optional Feature:
MSG_DISPATCH_BROADCAST_EN
- Defined: ID 8'hFF targets all NUM_DEST ports. DELIVER completes only after every port accepts, or on timeout (partial delivery counts as one drop).
- Undefined: 8'hFF is treated as an unknown ID and dropped with a count increment. No broadcast logic is synthesized.

Decomposition:
- Package msg_dispatch_pkg holds:
  - state enum (IDLE, DELIVER)
  - DEST_ID_WIDTH=8 and DEST_ID_LSB=0
  - BROADCAST_ID=8'hFF
  - DROP_COUNT_WIDTH=16
- One sub-module, msg_dispatch_timer:
  - clear/enable inputs, parameter TIMEOUT_CYCLES
  - expired output, high when count == TIMEOUT_CYCLES-1
  - counter width $clog2(TIMEOUT_CYCLES)

Test Plan:
1. Unicast, NUM_DEST=4. Header 32'h0000_0002, message 512'h0123...cdef, dest_ready_in=4'b0100 → dest_valid_out=4'b0100 one cycle after accept, for 1 cycle. Header and message outputs match. ctrl_ready_out returns to 1 the cycle after. drop_count_out=0.
2. Unknown ID. Header 32'hFAFA_FA07 → dest_valid_out stays 0. drop_count_out 0→1 next cycle. ctrl_ready_out never drops.
3. Broadcast (macro defined). Header 32'hBCBC_BCFF, ready[0..3] raised 3,1,0,2 cycles after valid → bits clear individually in order 2,1,3,0. IDLE after 4 DELIVER cycles. No drop.
4. Timeout, TIMEOUT_CYCLES=16. Header ID 1, dest_ready_in=0 → dest_valid_out[1] high exactly 16 cycles, then 0. drop_count_out=1. Also: ready asserted on cycle 16 → delivered, drop_count_out unchanged.
5. Reset mid-DELIVER. rst_in pulsed on cycle 5 of a unicast → next cycle dest_valid_out=0, ctrl_ready_out=1, drop_count_out=0.
6. Backpressure. Second bridge frame presented while first is in DELIVER → ctrl_ready_out=0 holds it. Second frame accepted in the first IDLE cycle. Both frames delivered intact, in order.
